// File: rtl/red_seq_unit_if.sv
// rtl/red_seq_unit_if.sv - operand/result handshake bundle for red_seq_unit
interface red_seq_unit_if #(
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              is_signed;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] result;

   modport master (
      output in_valid, a, b, is_signed, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, a, b, is_signed, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/red_seq_unit.sv
// rtl/red_seq_unit.sv - multi-cycle lane-sum reduction unit, one lane pair per cycle
module red_seq_unit #(
   parameter int LANE_W    = 4,
   parameter int NUM_LANES = 4,
   parameter int DATA_W    = LANE_W * NUM_LANES
) (
   input  logic           clk,
   input  logic           rst,
   red_seq_unit_if.slave  bus
);
   localparam int ACC_W = LANE_W + 1 + $clog2(NUM_LANES);
   localparam int IDX_W = $clog2(NUM_LANES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

   generate
      if (DATA_W < ACC_W) begin : g_bad_data_w
         $error("red_seq_unit: DATA_W must be at least ACC_W");
      end
      if ((NUM_LANES < 2) || ((NUM_LANES & (NUM_LANES - 1)) != 0)) begin : g_bad_lanes
         $error("red_seq_unit: NUM_LANES must be a power of 2, at least 2");
      end
      if (LANE_W < 2) begin : g_bad_lane_w
         $error("red_seq_unit: LANE_W must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t            state;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic              sgn_q;
   logic [ACC_W-1:0]  acc;
   logic [IDX_W-1:0]  idx;
   logic [ACC_W-1:0]  acc_next;

   function automatic logic [ACC_W-1:0] ext_lane(input logic [LANE_W-1:0] v, input logic s);
      if (s) return ACC_W'($signed(v));
      else   return ACC_W'(v);
   endfunction

   // ACC_W leaves headroom for 2*NUM_LANES lanes, so this sum never wraps
   always_comb begin
      acc_next = acc + ext_lane(a_q[idx*LANE_W +: LANE_W], sgn_q)
                     + ext_lane(b_q[idx*LANE_W +: LANE_W], sgn_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.result    <= '0;
         acc           <= '0;
         idx           <= '0;
         a_q           <= '0;
         b_q           <= '0;
         sgn_q         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q          <= bus.a;
                  b_q          <= bus.b;
                  sgn_q        <= bus.is_signed;
                  acc          <= '0;
                  idx          <= '0;
                  bus.in_ready <= 1'b0;
                  state        <= ACCUM;
               end
            end
            ACCUM: begin
               acc <= acc_next;
               idx <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  // result is formed from the final sum so it is ready on the DONE edge
                  if (sgn_q) bus.result <= DATA_W'($signed(acc_next));
                  else       bus.result <= DATA_W'(acc_next);
                  bus.out_valid <= 1'b1;
                  state         <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               bus.out_valid <= 1'b0;
               bus.in_ready  <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/red_seq_unit.md
Name: red_seq_unit

Overview:
Parametrised, multi-cycle successor to the 16-bit RED reduction datapath. It sums every LANE_W-bit lane of operands A and B into a single result, extended to DATA_W. Lanes can be treated as signed or unsigned. The block accumulates one lane pair per cycle behind valid/ready handshakes, so it sits in the EX stage as a stallable functional unit.

Parameters:
LANE_W, 4, width of one lane in bits (>=2)
NUM_LANES, 4, lanes per operand (power of 2, >=2)
DATA_W, LANE_W*NUM_LANES, operand and result width
ACC_W, LANE_W+1+$clog2(NUM_LANES), accumulator width (derived, not overridable; DATA_W >= ACC_W required, elaboration error otherwise)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands and mode valid
in_ready  output  1  unit can accept an operation
a  input  DATA_W  operand A, lane i = a[i*LANE_W +: LANE_W]
b  input  DATA_W  operand B, same lane mapping
is_signed  input  1  1 = lanes are two's-complement, 0 = unsigned
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
result  output  DATA_W  sum of all 2*NUM_LANES lanes, extended to DATA_W

Behaviour:
- Reset and clocking: single clock clk; reset rst is synchronous and active-high. Reset state is IDLE, in_ready=1, out_valid=0, result=0, accumulator=0, lane index=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE: in_ready=1. On an edge where in_valid&&in_ready:
  - register a, b and is_signed
  - clear the accumulator, set lane index to 0
  - go to ACCUM
- ACCUM: in_ready=0. Each edge adds ext(a lane idx) + ext(b lane idx) to the accumulator and increments idx.
  - ext = sign-extend to ACC_W if is_signed, else zero-extend.
  - After the edge processing lane NUM_LANES-1, go to DONE.
- DONE: out_valid=1, in_ready=0. result = accumulator extended to DATA_W (sign-extended if the latched is_signed, else zero-extended).
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
- Latency: out_valid rises exactly NUM_LANES cycles after the accepting edge. Minimum initiation interval is NUM_LANES+2 cycles (IDLE, NUM_LANES ACCUM cycles, DONE).
- Overflow: ACC_W is sized so the accumulator never overflows in either mode; no saturation or wrap logic is needed.
- Backpressure: while in DONE with out_ready=0, result and out_valid hold stable. in_valid is ignored in every state except IDLE.
- Operand stability: a, b and is_signed may change freely after the accepting edge; only latched copies are used.
- result is registered and holds its last value outside DONE; it is only meaningful while out_valid=1.
- Reset mid-operation (ACCUM or DONE): the operation is discarded. The next cycle is IDLE with out_valid=0, and no result is emitted.
- in_valid and rst asserted together: rst wins; no operation is accepted.

Test Plan:
- Unsigned, default parameters, a=16'h1234, b=16'h1111, out_ready=1 -> out_valid high 4 cycles after accept; result=16'h000E; returns to IDLE with in_ready=1 one cycle after the handshake.
- Unsigned maximum, a=b=16'hFFFF -> result=16'h0078 (120), no overflow.
- Signed, a=b=16'h8888 -> result=16'hFFC0 (-64). Signed, a=16'hFFFF, b=16'h0001 -> result=16'hFFFD (-3). Unsigned with the same a/b -> result=16'h003D (61).
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and a/b -> result and out_valid constant, in_ready=0, no new operation accepted; out_ready=1 completes the transfer.
- Pulse rst during the 2nd ACCUM cycle -> next cycle out_valid=0, in_ready=1. A following unsigned op a=16'h000F, b=16'h0000 -> result=16'h000F.
- Back-to-back plus parameter sweep with NUM_LANES=8, LANE_W=4, DATA_W=32:
  - signed a=b=32'h88888888 -> result=32'hFFFFFF80 (-128), out_valid 8 cycles after accept.
  - a second op accepted right after IDLE returns gives the correct independent result.
